// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline blocks.
//   NREG      : number of architectural registers (register 0 is hardwired)
//   REG_ZERO  : index of the hardwired zero register
//   reg_idx_t : 5-bit register index
package mips_pkg;

  localparam int NREG = 32;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_scoreboard_pend_counter.sv
// pend_counter: one saturating up/down counter of outstanding writes to a
// single register.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : a new write to this register was issued
//   dec      : a writeback to this register occurred (ignored when count is 0)
//   clr      : synchronous clear (flush); overrides inc/dec
//   nonzero  : count != 0 (register has a write in flight)
//   sat      : count is at its maximum
module pend_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic nonzero,
  output logic sat
);

  logic [CNT_W-1:0] cnt;
  logic             dec_eff;

  assign nonzero = (cnt != '0);
  assign sat     = (cnt == '1);
  // A writeback to an idle register is not an underflow; just drop it.
  assign dec_eff = dec & nonzero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec_eff && !sat) begin
      cnt <= cnt + 1'b1;
    end else if (dec_eff && !inc) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks registers with a result issued but not yet written
// back, and stalls decode on a read-after-write hazard.
//   clk, rst                      : clock, asynchronous active-high reset
//   issue_valid/rs/rt/uses_rt     : instruction presented by decode
//   issue_regwrite/issue_dest     : destination written by that instruction
//   wb_valid/wb_reg               : register-file writeback port
//   flush                         : synchronous clear of all pending state
//   stall                         : decode must hold (combinational)
//   issue_fire                    : instruction accepted this cycle
//   busy                          : some register has a write in flight
//   overflow_err                  : sticky, increment of a saturated counter
module reg_scoreboard #(
  parameter int NREG  = mips_pkg::NREG,
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  mips_pkg::reg_idx_t issue_rs,
  input  mips_pkg::reg_idx_t issue_rt,
  input  logic              issue_uses_rt,
  input  logic              issue_regwrite,
  input  mips_pkg::reg_idx_t issue_dest,
  input  logic              wb_valid,
  input  mips_pkg::reg_idx_t wb_reg,
  input  logic              flush,
  output logic              stall,
  output logic              issue_fire,
  output logic              busy,
  output logic              overflow_err
);

  import mips_pkg::*;

  logic [NREG-1:0] nz;
  logic [NREG-1:0] sat;
  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;
  logic [NREG-1:0] ovf;
  logic            rs_hit;
  logic            rt_hit;

  // Register 0 never holds a pending write.
  assign nz[0]  = 1'b0;
  assign sat[0] = 1'b0;
  assign inc[0] = 1'b0;
  assign dec[0] = 1'b0;
  assign ovf[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
      assign inc[gi] = issue_fire & issue_regwrite & (issue_dest == reg_idx_t'(gi));
      assign dec[gi] = wb_valid & (wb_reg == reg_idx_t'(gi));
      // A matching writeback in the same cycle cancels the increment, so
      // the count stays correct and nothing has overflowed.
      assign ovf[gi] = inc[gi] & sat[gi] & ~(dec[gi] & nz[gi]);

      pend_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (inc[gi]),
        .dec    (dec[gi]),
        .clr    (flush),
        .nonzero(nz[gi]),
        .sat    (sat[gi])
      );
    end
  endgenerate

  assign rs_hit     = (issue_rs != REG_ZERO) & nz[issue_rs];
  assign rt_hit     = issue_uses_rt & (issue_rt != REG_ZERO) & nz[issue_rt];
  // A same-cycle writeback does not release the stall: the register file
  // only holds the new value after this edge.
  assign stall      = issue_valid & (rs_hit | rt_hit);
  assign issue_fire = issue_valid & ~stall;
  assign busy       = |nz;

  // Flush discards the cycle's issue, so it cannot raise an overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_err <= 1'b0;
    end else if (!flush && (|ovf)) begin
      overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [4:0] issue_rs;
  logic [4:0] issue_rt;
  logic       issue_uses_rt;
  logic       issue_regwrite;
  logic [4:0] issue_dest;
  logic       wb_valid;
  logic [4:0] wb_reg;
  logic       flush;
  logic       stall;
  logic       issue_fire;
  logic       busy;
  logic       overflow_err;

  int checks = 0;
  int errors = 0;

  // Reference model: number of outstanding writes per register.
  int mcnt[32];
  bit movf;

  reg_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_rs      (issue_rs),
    .issue_rt      (issue_rt),
    .issue_uses_rt (issue_uses_rt),
    .issue_regwrite(issue_regwrite),
    .issue_dest    (issue_dest),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .flush         (flush),
    .stall         (stall),
    .issue_fire    (issue_fire),
    .busy          (busy),
    .overflow_err  (overflow_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_stall();
    return issue_valid && ((issue_rs != 0 && mcnt[issue_rs] > 0) ||
                           (issue_uses_rt && issue_rt != 0 && mcnt[issue_rt] > 0));
  endfunction

  function automatic bit m_busy();
    for (int i = 1; i < 32; i++) if (mcnt[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    movf = 1'b0;
  endtask

  // Advance one clock; the model applies this cycle's inputs at the edge.
  task automatic tick();
    bit st;
    int d;
    int w;
    st = m_stall();
    d = -1;
    w = -1;
    if (issue_valid && !st && issue_regwrite && issue_dest != 0) d = issue_dest;
    if (wb_valid && wb_reg != 0 && mcnt[wb_reg] > 0) w = wb_reg;
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
    end else if (!(d >= 0 && d == w)) begin
      if (d >= 0) begin
        if (mcnt[d] == 3) movf = 1'b1;
        else mcnt[d]++;
      end
      if (w >= 0) mcnt[w]--;
    end
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_uses_rt = 0;
    issue_regwrite = 0; issue_dest = 0; wb_valid = 0; wb_reg = 0; flush = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic rw, input logic [4:0] dest);
    issue_valid = 1; issue_rs = rs; issue_rt = rt; issue_uses_rt = uses_rt;
    issue_regwrite = rw; issue_dest = dest;
  endtask

  task automatic test_reset_state();
    idle();
    issue(5'd3, 5'd4, 1'b1, 1'b1, 5'd3);
    #1;
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0 || overflow_err !== 1'b0 || issue_fire !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: stall=%b busy=%b ovf=%b fire=%b, want 0 0 0 1",
               stall, busy, overflow_err, issue_fire);
    end
    $display("reset_state: stall=%b busy=%b ovf=%b fire=%b", stall, busy, overflow_err, issue_fire);
    idle();
    #1;
  endtask

  task automatic test_raw();
    idle();
    issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd3);
    tick();
    issue(5'd3, 5'd0, 1'b0, 1'b0, 5'd0);
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (stall !== 1'b1 || issue_fire !== 1'b0) begin
        errors++;
        $display("FAIL raw_hold cycle %0d: stall=%b fire=%b, want 1 0", c, stall, issue_fire);
      end
      $display("raw_hold cycle %0d: stall=%b fire=%b", c, stall, issue_fire);
      tick();
    end
    wb_valid = 1; wb_reg = 5'd3;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL raw_wb_cycle: stall=%b, want 1", stall);
    end
    $display("raw_wb_cycle: stall=%b", stall);
    tick();
    wb_valid = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || issue_fire !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL raw_release: stall=%b fire=%b busy=%b, want 0 1 0", stall, issue_fire, busy);
    end
    $display("raw_release: stall=%b fire=%b busy=%b", stall, issue_fire, busy);
    tick();
    idle();
  endtask

  task automatic test_simul_inc_dec();
    idle();
    issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd5);
    tick();
    issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd5);
    wb_valid = 1; wb_reg = 5'd5;
    tick();
    idle();
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL simul_busy: busy=%b, want 1", busy);
    end
    $display("simul_busy: busy=%b", busy);
    // One writeback must now be enough to drain $5 (count was 1, not 2).
    wb_valid = 1; wb_reg = 5'd5;
    tick();
    idle();
    issue(5'd5, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_drain: stall=%b busy=%b, want 0 0", stall, busy);
    end
    $display("simul_drain: stall=%b busy=%b", stall, busy);
    tick();
    idle();
  endtask

  task automatic test_zero_and_ignored();
    idle();
    issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd0);
    #1;
    checks++;
    if (stall !== 1'b0 || issue_fire !== 1'b1) begin
      errors++;
      $display("FAIL dest0_accept: stall=%b fire=%b, want 0 1", stall, issue_fire);
    end
    $display("dest0_accept: stall=%b fire=%b", stall, issue_fire);
    tick();
    #1;
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rs0_read: stall=%b busy=%b, want 0 0", stall, busy);
    end
    $display("rs0_read: stall=%b busy=%b", stall, busy);
    issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd7);
    tick();
    issue(5'd0, 5'd7, 1'b0, 1'b0, 5'd0);
    wb_valid = 1; wb_reg = 5'd0;
    #1;
    checks++;
    if (stall !== 1'b0 || issue_fire !== 1'b1) begin
      errors++;
      $display("FAIL rt_unused: stall=%b fire=%b, want 0 1", stall, issue_fire);
    end
    $display("rt_unused: stall=%b fire=%b", stall, issue_fire);
    issue_uses_rt = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rt_used: stall=%b, want 1", stall);
    end
    $display("rt_used: stall=%b", stall);
    tick();
    idle();
    wb_valid = 1; wb_reg = 5'd7;
    tick();
    wb_reg = 5'd12;   // count already 0: ignored
    tick();
    idle();
    #1;
    checks++;
    if (busy !== 1'b0 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL wb_idle: busy=%b ovf=%b, want 0 0", busy, overflow_err);
    end
    $display("wb_idle: busy=%b ovf=%b", busy, overflow_err);
  endtask

  task automatic test_saturation();
    idle();
    for (int k = 1; k <= 4; k++) begin
      issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd9);
      tick();
      idle();
      #1;
      checks++;
      if (overflow_err !== (k == 4)) begin
        errors++;
        $display("FAIL sat_issue %0d: ovf=%b, want %b", k, overflow_err, k == 4);
      end
      $display("sat_issue %0d: ovf=%b busy=%b", k, overflow_err, busy);
    end
    for (int k = 1; k <= 3; k++) begin
      wb_valid = 1; wb_reg = 5'd9;
      tick();
      idle();
      #1;
      checks++;
      if (busy !== (k < 3) || overflow_err !== 1'b1) begin
        errors++;
        $display("FAIL sat_wb %0d: busy=%b ovf=%b, want %b 1", k, busy, overflow_err, k < 3);
      end
      $display("sat_wb %0d: busy=%b ovf=%b", k, busy, overflow_err);
    end
  endtask

  task automatic test_reset_midrun();
    idle();
    issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd3);
    tick();
    issue(5'd3, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    checks++;
    if (stall !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: stall=%b busy=%b, want 1 1", stall, busy);
    end
    $display("pre_reset: stall=%b busy=%b ovf=%b", stall, busy, overflow_err);
    rst = 1;
    #1;
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0 || overflow_err !== 1'b0 || issue_fire !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: stall=%b busy=%b ovf=%b fire=%b, want 0 0 0 1",
               stall, busy, overflow_err, issue_fire);
    end
    $display("async_reset: stall=%b busy=%b ovf=%b fire=%b", stall, busy, overflow_err, issue_fire);
    #1;
    rst = 0;
    model_clear();
    idle();
    @(negedge clk);
  endtask

  task automatic test_flush();
    idle();
    issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd2);
    tick();
    issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd4);
    tick();
    issue(5'd0, 5'd0, 1'b0, 1'b1, 5'd6);
    wb_valid = 1; wb_reg = 5'd2;
    flush = 1;
    #1;
    checks++;
    if (stall !== 1'b0 || issue_fire !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle: stall=%b fire=%b busy=%b, want 0 1 1", stall, issue_fire, busy);
    end
    $display("flush_cycle: stall=%b fire=%b busy=%b", stall, issue_fire, busy);
    tick();
    idle();
    issue(5'd6, 5'd4, 1'b1, 1'b0, 5'd0);
    #1;
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: stall=%b busy=%b, want 0 0", stall, busy);
    end
    $display("flush_after: stall=%b busy=%b", stall, busy);
    tick();
    idle();
  endtask

  task automatic test_self_dep();
    idle();
    issue(5'd11, 5'd0, 1'b0, 1'b1, 5'd11);
    #1;
    checks++;
    if (stall !== 1'b0 || issue_fire !== 1'b1) begin
      errors++;
      $display("FAIL self_dep: stall=%b fire=%b, want 0 1", stall, issue_fire);
    end
    $display("self_dep: stall=%b fire=%b", stall, issue_fire);
    tick();
    issue(5'd11, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL self_dep_pending: stall=%b, want 1", stall);
    end
    $display("self_dep_pending: stall=%b", stall);
    idle();
    wb_valid = 1; wb_reg = 5'd11;
    tick();
    idle();
  endtask

  task automatic test_random();
    bit es;
    for (int n = 0; n < 400; n++) begin
      issue_valid    = ($urandom_range(3) != 0);
      issue_rs       = 5'($urandom_range(7));
      issue_rt       = 5'($urandom_range(7));
      issue_uses_rt  = 1'($urandom_range(1));
      issue_regwrite = ($urandom_range(3) != 0);
      issue_dest     = 5'($urandom_range(7));
      wb_valid       = ($urandom_range(2) != 0);
      wb_reg         = 5'($urandom_range(7));
      flush          = ($urandom_range(31) == 0);
      #1;
      es = m_stall();
      checks++;
      if (stall !== es || issue_fire !== (issue_valid && !es) ||
          busy !== m_busy() || overflow_err !== movf) begin
        errors++;
        $display("FAIL random %0d: stall=%b fire=%b busy=%b ovf=%b, want %b %b %b %b",
                 n, stall, issue_fire, busy, overflow_err, es, issue_valid && !es, m_busy(), movf);
      end
      $display("random %0d: v=%b rs=%0d rt=%0d urt=%b rw=%b d=%0d wb=%b/%0d fl=%b -> stall=%b busy=%b ovf=%b",
               n, issue_valid, issue_rs, issue_rt, issue_uses_rt, issue_regwrite, issue_dest,
               wb_valid, wb_reg, flush, stall, busy, overflow_err);
      tick();
    end
    idle();
  endtask

  initial begin
    model_clear();
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    test_reset_state();
    test_raw();
    test_simul_inc_dec();
    test_zero_and_ignored();
    test_self_dep();
    test_saturation();
    test_reset_midrun();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight writes to the 32x32 register file: which registers have a result issued but not yet written back.
- Decode consults it to stall an instruction whose source operands are still pending.
- Sits beside the register file: set from the decode/issue stage, cleared from the MEM/WB writeback port.
- Provides the operand-hazard sequencing the pipeline needs when no forwarding network is present.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired and never pending.
- CNT_W, 2, width of the per-register pending counter; max 2^CNT_W-1 outstanding writes per register.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction this cycle.
- issue_rs  in  5  source register 1.
- issue_rt  in  5  source register 2.
- issue_uses_rt  in  1  rt is a true source (R-type, beq, sw); 0 for I-type loads/ALU-imm.
- issue_regwrite  in  1  instruction will write issue_dest.
- issue_dest  in  5  destination register.
- wb_valid  in  1  writeback occurs this cycle (same signal as register-file regwrite).
- wb_reg  in  5  writeback register (same as writebackreg).
- flush  in  1  synchronous clear of all pending state (branch squash).
- stall  out  1  decode must hold; combinational from state and issue inputs.
- issue_fire  out  1  issue_valid & ~stall; the instruction is accepted this cycle.
- busy  out  1  any register has a nonzero counter.
- overflow_err  out  1  sticky: issue attempted to increment a saturated counter.

Behaviour:
- State: pend_cnt[1..NREG-1], CNT_W bits each; overflow_err flag.
- Reset (async, rst=1): all counters 0, overflow_err 0. Outputs then read stall=0, busy=0, issue_fire=issue_valid.
- Hazard:
  - rs_hit = (issue_rs!=0) & pend_cnt[issue_rs]!=0.
  - rt_hit = issue_uses_rt & (issue_rt!=0) & pend_cnt[issue_rt]!=0.
  - stall = issue_valid & (rs_hit | rt_hit).
- Per register r!=0, each posedge:
  - inc = issue_fire & issue_regwrite & issue_dest==r.
  - dec = wb_valid & wb_reg==r & pend_cnt[r]!=0.
  - inc&dec: unchanged. inc only: +1. dec only: -1.
- Writeback to a register with count 0 (incl. r0): ignored, no error.
- Issue with dest 0: no state change, but still accepted.
- Saturation: inc on a counter at max holds the value and sets overflow_err. Only rst clears overflow_err.
- Same-cycle wb and dependent decode: stall stays asserted that cycle. The register file writes at the same edge, so decode proceeds next cycle with correct data. Latency from wb to stall release is 1 cycle.
- flush=1: at the next edge all counters go to 0, and any same-cycle issue and wb updates are discarded. stall is not forced by flush.
- Self-dependency (rs==dest, not pending): no stall; the instruction is accepted and dest becomes pending.
- busy = OR of all counters !=0, from registered state.

Decomposition:
- Shared package mips_pkg:
  - REG_ZERO=5'd0 and NREG.
  - Register index typedef reg_idx_t (5 bits).
- One sub-module, pend_counter: single saturating up/down counter with inc, dec, clr, sat outputs, instantiated NREG-1 times via generate. Hazard compare logic stays in the top.

Test Plan:
- Reset: assert rst mid-run with counters nonzero -> immediately stall=0, busy=0, overflow_err=0, without waiting for clk.
- RAW stall: issue add dest=$3; next cycle issue rs=$3 -> stall=1 until wb_valid wb_reg=3. In the wb cycle stall=1; next cycle stall=0, issue_fire=1.
- Simultaneous inc/dec: $5 count=1; same cycle issue dest=$5 and wb $5 -> count stays 1, busy stays 1.
- Ignored sources and register zero:
  - Issue dest=$0, then rs=$0 -> never stall, busy=0.
  - With $7 pending, issue with rt=$7 and issue_uses_rt=0 -> no stall.
- Saturation: four issues to $9 with no wb (CNT_W=2) -> count 3, overflow_err=1 on the fourth. Three wbs -> count 0, overflow_err still 1.
- Flush: $2, $4 pending; flush with concurrent issue dest=$6 -> after edge all counts 0, busy=0, $6 not pending.
